// File: rtl/tlb_assoc.sv
// rtl/tlb_assoc.sv - set-associative TLB with age-based replacement and single-miss refill (optional TLB_WRITE_PROT_EN)
module tlb_assoc #(
   parameter int SETS  = 4,
   parameter int WAYS  = 4,
   parameter int VPN_W = 20,
   parameter int PPN_W = 8,
   parameter int OFF_W = 12,
   parameter int AGE_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mode,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [VPN_W+OFF_W-1:0] req_vaddr,
   input  logic                   req_store,
   output logic                   resp_valid,
   output logic [PPN_W+OFF_W-1:0] resp_paddr,
   output logic                   resp_fault,
   output logic                   miss_req,
   output logic [VPN_W-1:0]       miss_vpn,
   input  logic                   fill_valid,
   input  logic [PPN_W-1:0]       fill_ppn,
   input  logic                   fill_wr,
   input  logic                   flush
);

   localparam int IDX_W = (SETS > 1) ? $clog2(SETS) : 1;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [AGE_W-1:0] AGE_MAX = '1;

   typedef enum logic [1:0] {IDLE, MISS, FILL} state_t;

   state_t state;
   logic   ready_en;

   logic             valid_q [SETS][WAYS];
   logic [AGE_W-1:0] age_q   [SETS][WAYS];
   logic [VPN_W-1:0] tag_q   [SETS][WAYS];
   logic [PPN_W-1:0] ppn_q   [SETS][WAYS];

   logic [VPN_W-1:0] vpn;
   logic [OFF_W-1:0] offset;
   logic [IDX_W-1:0] idx;
   logic             accept;

   logic [OFF_W-1:0] lat_off;
   logic [IDX_W-1:0] lat_idx;

   logic             hit;
   logic [WAY_W-1:0] hit_way;
   logic [WAY_W-1:0] victim;
   logic             victim_found;
   logic [AGE_W-1:0] victim_age;
   logic             fill_fire;
   logic             hit_fault;
   logic             fill_fault;

   assign vpn       = req_vaddr[VPN_W+OFF_W-1:OFF_W];
   assign offset    = req_vaddr[OFF_W-1:0];
   assign idx       = (SETS > 1) ? vpn[IDX_W-1:0] : '0;
   assign req_ready = ready_en && (state == IDLE) && !flush;
   assign accept    = req_valid && req_ready;
   assign fill_fire = (state == MISS) && fill_valid && !flush;

`ifdef TLB_WRITE_PROT_EN
   logic wr_q [SETS][WAYS];
   logic lat_store;

   assign hit_fault  = req_store && !wr_q[idx][hit_way];
   assign fill_fault = lat_store && !fill_wr;

   // Latch the store flag of a missing request so the fill can judge it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         lat_store <= 1'b0;
      else if (accept && !mode)
         lat_store <= req_store;
   end
`else
   logic unused_wp;

   assign hit_fault  = 1'b0;
   assign fill_fault = 1'b0;
   assign unused_wp  = &{1'b0, req_store, fill_wr};
`endif

   // Tag match in the indexed set; the first matching valid way wins
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!hit && valid_q[idx][w] && (tag_q[idx][w] == vpn)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   // Victim: lowest invalid way, else oldest way with ties to the lowest index
   always_comb begin
      victim_found = 1'b0;
      victim       = '0;
      victim_age   = age_q[lat_idx][0];
      for (int w = 0; w < WAYS; w++) begin
         if (!victim_found && !valid_q[lat_idx][w]) begin
            victim_found = 1'b1;
            victim       = WAY_W'(w);
         end
      end
      if (!victim_found) begin
         for (int w = 1; w < WAYS; w++) begin
            if (age_q[lat_idx][w] > victim_age) begin
               victim_age = age_q[lat_idx][w];
               victim     = WAY_W'(w);
            end
         end
      end
   end

   // Valid bits and ages: flush clears, user lookups age the set, fills install
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
               age_q[s][w]   <= '0;
            end
         end
      end else if (flush) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
            end
         end
      end else if (accept && !mode) begin
         for (int w = 0; w < WAYS; w++) begin
            if (hit && (WAY_W'(w) == hit_way))
               age_q[idx][w] <= '0;
            else if (valid_q[idx][w] && (age_q[idx][w] != AGE_MAX))
               age_q[idx][w] <= age_q[idx][w] + 1'b1;
         end
      end else if (fill_fire) begin
         valid_q[lat_idx][victim] <= 1'b1;
         age_q[lat_idx][victim]   <= '0;
      end
   end

   // Entry payload needs no reset; it is only meaningful behind a valid bit
   always_ff @(posedge clk) begin
      if (fill_fire) begin
         tag_q[lat_idx][victim] <= miss_vpn;
         ppn_q[lat_idx][victim] <= fill_ppn;
`ifdef TLB_WRITE_PROT_EN
         wr_q[lat_idx][victim]  <= fill_wr;
`endif
      end
   end

   // Request FSM with registered response and refill outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         ready_en   <= 1'b0;
         resp_valid <= 1'b0;
         resp_paddr <= '0;
         resp_fault <= 1'b0;
         miss_req   <= 1'b0;
         miss_vpn   <= '0;
         lat_off    <= '0;
         lat_idx    <= '0;
      end else begin
         ready_en   <= 1'b1;
         resp_valid <= 1'b0;
         if (flush) begin
            state    <= IDLE;
            miss_req <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (accept) begin
                     if (mode) begin
                        resp_valid <= 1'b1;
                        resp_paddr <= req_vaddr[PPN_W+OFF_W-1:0];
                        resp_fault <= 1'b0;
                     end else if (hit) begin
                        resp_valid <= 1'b1;
                        resp_fault <= hit_fault;
                        resp_paddr <= hit_fault ? '0 : {ppn_q[idx][hit_way], offset};
                     end else begin
                        state    <= MISS;
                        miss_req <= 1'b1;
                        miss_vpn <= vpn;
                        lat_off  <= offset;
                        lat_idx  <= idx;
                     end
                  end
               end
               MISS: begin
                  if (fill_valid) begin
                     state      <= FILL;
                     miss_req   <= 1'b0;
                     resp_valid <= 1'b1;
                     resp_fault <= fill_fault;
                     resp_paddr <= fill_fault ? '0 : {fill_ppn, lat_off};
                  end
               end
               FILL:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/tlb_assoc.md
TLB_ASSOC -- requirements
Module: tlb_assoc

Interface
REQ-001 SHALL have parameters (one per line: name, default, meaning):
- SETS, 4, number of sets, power of two, at least 1.
- WAYS, 4, entries per set, at least 1.
- VPN_W, 20, virtual page number width.
- PPN_W, 8, physical page number width.
- OFF_W, 12, page offset width.
- AGE_W, 4, per-entry age counter width.
REQ-002 SHALL have ports (one per line: name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous, active-low reset.
- mode, in, 1, 1 = supervisor (translation bypassed), 0 = user.
- req_valid, in, 1, translation request.
- req_ready, out, 1, request accepted when req_valid && req_ready.
- req_vaddr, in, VPN_W+OFF_W, virtual address.
- req_store, in, 1, request is a store.
- resp_valid, out, 1, one-cycle pulse, response valid.
- resp_paddr, out, PPN_W+OFF_W, physical address.
- resp_fault, out, 1, permission fault.
- miss_req, out, 1, refill request, held until fill.
- miss_vpn, out, VPN_W, VPN to refill.
- fill_valid, in, 1, refill data valid.
- fill_ppn, in, PPN_W, refill PPN.
- fill_wr, in, 1, refill page writable.
- flush, in, 1, invalidate all entries.

Function
REQ-003 SHALL split req_vaddr into vpn = [VPN_W+OFF_W-1:OFF_W] and offset = [OFF_W-1:0]; the set index is vpn[log2(SETS)-1:0], or 0 when SETS=1.
REQ-004 SHALL implement FSM IDLE, MISS, FILL; req_ready=1 only in IDLE with flush=0.
REQ-005 SHALL, on an accepted request with mode=1, pulse resp_valid the next cycle with resp_paddr = req_vaddr[PPN_W+OFF_W-1:0], resp_fault=0, and no entry or age change.
REQ-006 SHALL, on an accepted request with mode=0 that hits (valid entry, matching VPN, in the indexed set), pulse resp_valid the next cycle with resp_paddr = {ppn, offset}; FSM stays IDLE.
REQ-007 SHALL, on a mode=0 miss, latch the request, go to MISS, and assert miss_req with miss_vpn = latched vpn from the next cycle until the fill cycle inclusive.
REQ-008 SHALL, in MISS with fill_valid=1, write the victim way (valid=1, vpn, fill_ppn, fill_wr, age=0), go to FILL, then pulse resp_valid the following cycle with {fill_ppn, latched offset}, and return to IDLE. Miss latency is the fill cycle + 1.
REQ-009 SHALL select the victim as the lowest-index invalid way; if all ways are valid, the way with maximum age; ties go to the lowest index.
REQ-010 SHALL, on each user lookup in a set: reset the hit way's age to 0 and increment every other valid way in that set, saturating at 2^AGE_W-1 with no wrap.
REQ-011 SHALL ignore fill_valid outside MISS.
REQ-012 SHALL, on flush, clear all valid bits at the next edge. If flush occurs in MISS or FILL, the pending request is dropped with no resp_valid, the FSM returns to IDLE, and miss_req deasserts.
REQ-013 SHALL give flush priority over a simultaneous fill_valid (fill discarded) and over req_valid (req_ready=0).
REQ-014 SHALL not change mode semantics mid-request; mode is sampled at acceptance only.
REQ-015 SHALL allow a new request to be accepted in the same cycle a hit response is pulsed (back-to-back throughput of 1 per cycle on hits).

Reset
REQ-016 SHALL, while rst=0, asynchronously force: all valid bits 0, all ages 0, FSM IDLE, req_ready 0, resp_valid 0, resp_paddr 0, resp_fault 0, miss_req 0, miss_vpn 0.
REQ-017 SHALL, on reset asserted mid-miss, discard the pending request; no response is issued after release.

Configuration
REQ-018 SHALL, with TLB_WRITE_PROT_EN defined, store fill_wr per entry; a user store that hits or fills a non-writable entry responds with resp_fault=1 and resp_paddr=0, with ages still updated.
REQ-019 SHALL, without TLB_WRITE_PROT_EN, not store the writable bit, ignore fill_wr and req_store, and tie resp_fault to 0.

Verification
REQ-020 Cold miss: mode=0, vaddr=0x12345ABC -> miss_req=1, miss_vpn=0x12345; fill_ppn=0x7F -> resp_paddr=0x7FABC one cycle after fill.
REQ-021 Hit: repeat vaddr=0x12345010 -> resp_paddr=0x7F010 one cycle after acceptance, no miss_req.
REQ-022 Replacement: SETS=4, WAYS=4; fill VPNs 0x00,0x04,0x08,0x0C, hit 0x00, then miss 0x10 -> way of 0x04 evicted; a subsequent 0x04 lookup misses.
REQ-023 Flush during MISS: flush=1 together with fill_valid -> no resp_valid, miss_req=0 next cycle, all entries invalid.
REQ-024 Supervisor: mode=1, vaddr=0xFFFFF123 -> resp_paddr=0xFF123, no miss, ages unchanged.
REQ-025 With TLB_WRITE_PROT_EN: fill_wr=0, store hit -> resp_fault=1, resp_paddr=0; the same access as a load -> resp_fault=0.
